// File: rtl/fir_out_stage_if.sv
// Handshake bundle between the FIR accumulator, the output stage and the sample consumer.
interface fir_out_stage_if #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
);
    logic [ACC_W-1:0] acc_in;
    logic             acc_valid;
    logic [OUT_W-1:0] y_out;
    logic             y_valid;
    logic             y_ready;
    logic             full;
    logic             ovf_sticky;
    logic             clr_ovf;
    logic [7:0]       sat_cnt;

    // master: filter + consumer side; slave: the output stage itself
    modport master (
        output acc_in, acc_valid, y_ready, clr_ovf,
        input  y_out, y_valid, full, ovf_sticky, sat_cnt
    );
    modport slave (
        input  acc_in, acc_valid, y_ready, clr_ovf,
        output y_out, y_valid, full, ovf_sticky, sat_cnt
    );
endinterface

// File: rtl/fir_out_stage.sv
// FIR output stage: round/shift/saturate the accumulator, register it, and buffer it in a
// show-ahead FIFO toward a valid/ready consumer, flagging drops and clips.
module fir_out_stage #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           global_reset,
    fir_out_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    logic signed [ACC_W:0] ext, sum, shr;
    logic                  clip_hi, clip_lo;
    logic [OUT_W-1:0]      sat_val;

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    always_comb begin
        ext     = {bus.acc_in[ACC_W-1], bus.acc_in};
        sum     = ext + RND;
        shr     = sum >>> SHIFT;
        clip_hi = shr > MAXV;
        clip_lo = shr < MINV;
        sat_val = clip_hi ? MAXV[OUT_W-1:0] :
                  clip_lo ? MINV[OUT_W-1:0] : shr[OUT_W-1:0];
    end

    logic             stg_vld;
    logic [OUT_W-1:0] stg_data;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic [7:0]       sat_cnt;
    logic             pop, push, drop, is_full;

    always_comb begin
        is_full = (count == FULL_CNT);
        pop     = (count != '0) && bus.y_ready;
        push    = stg_vld && (!is_full || pop);
        drop    = stg_vld && is_full && !pop;
    end

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            stg_vld  <= 1'b0;
            stg_data <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            sat_cnt  <= '0;
        end else begin
            stg_vld <= bus.acc_valid;
            if (bus.acc_valid) stg_data <= sat_val;
            if (bus.acc_valid && (clip_hi || clip_lo) && sat_cnt != 8'hFF)
                sat_cnt <= sat_cnt + 8'd1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A fresh drop outranks a clear in the same cycle.
            if (drop)             ovf <= 1'b1;
            else if (bus.clr_ovf) ovf <= 1'b0;
        end
    end

    // Storage needs no reset: reads are masked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= stg_data;
    end

    assign bus.y_out      = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.y_valid    = (count != '0);
    assign bus.full       = is_full;
    assign bus.ovf_sticky = ovf;
    assign bus.sat_cnt    = sat_cnt;
endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage at ACC_W=16, OUT_W=8, SHIFT=4, DEPTH=4.
module tb_fir_out_stage;
    logic clk = 1'b0;
    logic global_reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    fir_out_stage_if #(.ACC_W(16), .OUT_W(8)) bus ();

    fir_out_stage #(.ACC_W(16), .OUT_W(8), .SHIFT(4), .DEPTH(4)) dut (
        .clk(clk), .global_reset(global_reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] v);
        bus.acc_in = v;
        bus.acc_valid = 1'b1;
        step();
        bus.acc_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.acc_in = '0; bus.acc_valid = 1'b0; bus.y_ready = 1'b0; bus.clr_ovf = 1'b0;
        global_reset = 1'b0;
        step(); step();
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL reset_y_valid: got %b want 0", bus.y_valid); end
        n_cmp++; if (bus.y_out !== 8'h00) begin n_err++; $display("FAIL reset_y_out: got %h want 00", bus.y_out); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.ovf_sticky); end
        n_cmp++; if (bus.sat_cnt !== 8'd0) begin n_err++; $display("FAIL reset_sat_cnt: got %0d want 0", bus.sat_cnt); end
        global_reset = 1'b1;
        step();
    endtask

    task automatic test_round();
        bus.y_ready = 1'b1;
        pulse(16'h0123);
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL round_s1_valid: got %b want 0", bus.y_valid); end
        step();
        n_cmp++; if (bus.y_valid !== 1'b1) begin n_err++; $display("FAIL round_s2_valid: got %b want 1", bus.y_valid); end
        n_cmp++; if (bus.y_out !== 8'h12) begin n_err++; $display("FAIL round_y_out: got %h want 12", bus.y_out); end
        step();
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL round_s3_valid: got %b want 0", bus.y_valid); end
    endtask

    task automatic test_clip();
        bus.y_ready = 1'b1;
        pulse(16'hFFE8); step();
        n_cmp++; if (bus.y_out !== 8'hFF) begin n_err++; $display("FAIL neg_round: got %h want FF", bus.y_out); end
        pulse(16'h7FFF); step();
        n_cmp++; if (bus.y_out !== 8'h7F) begin n_err++; $display("FAIL clip_hi: got %h want 7F", bus.y_out); end
        pulse(16'h8000); step();
        n_cmp++; if (bus.y_out !== 8'h80) begin n_err++; $display("FAIL clip_lo: got %h want 80", bus.y_out); end
        step();
        n_cmp++; if (bus.sat_cnt !== 8'd2) begin n_err++; $display("FAIL sat_cnt_2: got %0d want 2", bus.sat_cnt); end
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL clip_drained: got %b want 0", bus.y_valid); end
    endtask

    task automatic test_backpressure();
        bus.y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.acc_in = 16'(16'h0010 * (i + 1));
            bus.acc_valid = 1'b1;
            step();
        end
        bus.acc_valid = 1'b0;
        step();
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL bp_full: got %b want 1", bus.full); end
        n_cmp++; if (bus.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL bp_ovf: got %b want 1", bus.ovf_sticky); end
        step();
        n_cmp++; if (bus.y_out !== 8'h01) begin n_err++; $display("FAIL bp_held_head: got %h want 01", bus.y_out); end
        bus.y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.y_valid !== 1'b1 || bus.y_out !== 8'(i + 1)) begin
                n_err++; $display("FAIL bp_drain_%0d: got v=%b %h want v=1 %h", i, bus.y_valid, bus.y_out, 8'(i + 1));
            end
            step();
        end
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", bus.y_valid); end
    endtask

    task automatic test_clr_ovf();
        bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
        n_cmp++; if (bus.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL clr_plain: got %b want 0", bus.ovf_sticky); end
        bus.y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.acc_in = 16'h0100;
            bus.acc_valid = 1'b1;
            step();
        end
        bus.acc_valid = 1'b0;
        // The fifth sample is dropped at the end of this cycle.
        bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
        n_cmp++; if (bus.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL clr_vs_drop: got %b want 1", bus.ovf_sticky); end
        bus.y_ready = 1'b1;
        repeat (4) step();
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL clr_drain_empty: got %b want 0", bus.y_valid); end
        bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
    endtask

    task automatic test_full_pop();
        bus.y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.acc_in = 16'(16'h0050 + 16'h0010 * i);
            bus.acc_valid = 1'b1;
            step();
        end
        bus.acc_valid = 1'b0;
        n_cmp++; if (bus.full !== 1'b1 || bus.y_out !== 8'h05) begin n_err++; $display("FAIL fp_full_head: got full=%b %h want full=1 05", bus.full, bus.y_out); end
        bus.y_ready = 1'b1;
        step();
        n_cmp++; if (bus.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL fp_no_drop: got %b want 0", bus.ovf_sticky); end
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fp_still_full: got %b want 1", bus.full); end
        for (int i = 6; i <= 9; i++) begin
            n_cmp++;
            if (bus.y_valid !== 1'b1 || bus.y_out !== 8'(i)) begin
                n_err++; $display("FAIL fp_order_%0d: got v=%b %h want v=1 %h", i, bus.y_valid, bus.y_out, 8'(i));
            end
            step();
        end
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL fp_empty: got %b want 0", bus.y_valid); end
    endtask

    task automatic test_reset_mid();
        bus.y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.acc_in = 16'(16'h0010 * (i + 1));
            bus.acc_valid = 1'b1;
            step();
        end
        bus.acc_valid = 1'b0;
        global_reset = 1'b0;
        #1;
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL rm_y_valid: got %b want 0", bus.y_valid); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL rm_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.sat_cnt !== 8'd0) begin n_err++; $display("FAIL rm_sat_cnt: got %0d want 0", bus.sat_cnt); end
        step();
        global_reset = 1'b1;
        step(); step();
        n_cmp++; if (bus.y_valid !== 1'b0) begin n_err++; $display("FAIL rm_stage_flushed: got %b want 0", bus.y_valid); end
        bus.y_ready = 1'b1;
        pulse(16'h0200); step();
        n_cmp++; if (bus.y_valid !== 1'b1 || bus.y_out !== 8'h20) begin n_err++; $display("FAIL rm_after: got v=%b %h want v=1 20", bus.y_valid, bus.y_out); end
        step();
    endtask

    task automatic test_sat_hold();
        bus.y_ready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            bus.acc_in = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
            bus.acc_valid = 1'b1;
            step();
        end
        bus.acc_valid = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.sat_cnt !== 8'd255) begin n_err++; $display("FAIL sat_hold: got %0d want 255", bus.sat_cnt); end
        n_cmp++; if (bus.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL sat_no_drop: got %b want 0", bus.ovf_sticky); end
    endtask

    initial begin
        test_reset();
        test_round();
        test_clip();
        test_backpressure();
        test_clr_ovf();
        test_full_pop();
        test_reset_mid();
        test_sat_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
